// File: rtl/conv_pkg.sv
// Shared width defaults, FSM state encoding and reset values for the 8<->32 link converters.
package conv_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int BYTE_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    localparam logic [WORD_W_DEF-1:0] DATA_OUT_RST = '0;

endpackage

// File: rtl/conv_8_32.sv
// Byte-to-word assembler: collects NBYTES consecutive valid bytes MSB-first into one word.
// Optional abort reporting (abort_err pulse, saturating abort_cnt) under CONV_8_32_ABORT_ERR_EN.
module conv_8_32
    import conv_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid_in,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              busy
`ifdef CONV_8_32_ABORT_ERR_EN
    ,
    output logic              abort_err,
    output logic [7:0]        abort_cnt
`endif
);

    localparam int NBYTES = WORD_W / BYTE_W;
    localparam int SHW    = WORD_W - BYTE_W;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SHW-1:0]      sh_q, sh_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                vld_q, vld_d;
    logic                busy_q, busy_d;
    logic                abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    sh_d    = SHW'(data_in);
                    cnt_d   = CW'(1);
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (!valid_in) begin
                    // Gap inside a word: drop the fragment, output word untouched.
                    abort   = 1'b1;
                    sh_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(NBYTES - 1)) begin
                    data_d  = {sh_q, data_in};
                    vld_d   = 1'b1;
                    sh_d    = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    sh_d  = SHW'({sh_q, data_in});
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= WORD_W'(DATA_OUT_RST);
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = vld_q;
    assign busy      = busy_q;

`ifdef CONV_8_32_ABORT_ERR_EN
    logic       abort_err_q;
    logic [7:0] abort_cnt_q;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            abort_err_q <= 1'b0;
            abort_cnt_q <= 8'h00;
        end else begin
            abort_err_q <= abort;
            if (abort && abort_cnt_q != 8'hFF)
                abort_cnt_q <= abort_cnt_q + 8'h01;
        end
    end

    assign abort_err = abort_err_q;
    assign abort_cnt = abort_cnt_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_conv_8_32.sv
// Self-checking bench for conv_8_32: scoreboard of expected words checked on every valid_out strobe.
module tb_conv_8_32;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        busy;
`ifdef CONV_8_32_ABORT_ERR_EN
    logic        abort_err;
    logic [7:0]  abort_cnt;
`endif

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    conv_8_32 dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy)
`ifdef CONV_8_32_ABORT_ERR_EN
        ,
        .abort_err (abort_err),
        .abort_cnt (abort_cnt)
`endif
    );

    always #5 clk_4f = ~clk_4f;

    // Scoreboard: every strobe must match the oldest outstanding expected word.
    always @(negedge clk_4f) begin
        if (valid_out === 1'b1) begin
            logic [31:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL strobe_unexpected: data_out=%h, no word expected", data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e)
                    $display("FAIL strobe_data: data_out=%h expected=%h", data_out, e);
                else
                    passed++;
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'hAA);
            checks++;
            if (data_out !== 32'h0 || valid_out !== 1'b0 || busy !== 1'b0)
                $display("FAIL reset_hold: data_out=%h valid_out=%b busy=%b expected 0/0/0",
                         data_out, valid_out, busy);
            else
                passed++;
        end
`ifdef CONV_8_32_ABORT_ERR_EN
        checks++;
        if (abort_err !== 1'b0 || abort_cnt !== 8'h00)
            $display("FAIL reset_abort: abort_err=%b abort_cnt=%h expected 0/00", abort_err, abort_cnt);
        else
            passed++;
`endif
        reset = 1'b0;
        cyc(1'b0, 8'h00);
    endtask

    task automatic test_single_word;
        logic [7:0] b[4] = '{8'hFD, 8'h55, 8'h44, 8'h88};
        exp_q.push_back(32'hFD554488);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, b[i]);
            checks++;
            if (busy !== (i != 3) || valid_out !== (i == 3))
                $display("FAIL single_busy_vld: byte %0d busy=%b valid_out=%b expected %b/%b",
                         i, busy, valid_out, i != 3, i == 3);
            else
                passed++;
        end
        cyc(1'b0, 8'h00);
        checks++;
        if (valid_out !== 1'b0 || data_out !== 32'hFD554488)
            $display("FAIL single_hold: valid_out=%b data_out=%h expected 0/fd554488", valid_out, data_out);
        else
            passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] b[8] = '{8'hFF, 8'hAA, 8'hBB, 8'h22, 8'hCC, 8'hBB, 8'hAA, 8'hFF};
        exp_q.push_back(32'hFFAABB22);
        exp_q.push_back(32'hCCBBAAFF);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, b[i]);
            checks++;
            if (valid_out !== (i == 3 || i == 7))
                $display("FAIL b2b_strobe: byte %0d valid_out=%b expected %b", i, valid_out, i == 3 || i == 7);
            else
                passed++;
        end
        cyc(1'b0, 8'h00);
    endtask

    task automatic test_gap_abort;
        cyc(1'b1, 8'h12);
        cyc(1'b1, 8'h34);
        cyc(1'b0, 8'h00);
        checks++;
        if (busy !== 1'b0 || valid_out !== 1'b0 || data_out !== 32'hCCBBAAFF)
            $display("FAIL abort_state: busy=%b valid_out=%b data_out=%h expected 0/0/ccbbaaff",
                     busy, valid_out, data_out);
        else
            passed++;
        exp_q.push_back(32'h56789ABC);
`ifdef CONV_8_32_ABORT_ERR_EN
        checks++;
        if (abort_err !== 1'b1 || abort_cnt !== 8'h01)
            $display("FAIL abort_err_pulse: abort_err=%b abort_cnt=%h expected 1/01", abort_err, abort_cnt);
        else
            passed++;
`endif
        cyc(1'b1, 8'h56);
`ifdef CONV_8_32_ABORT_ERR_EN
        checks++;
        if (abort_err !== 1'b0 || abort_cnt !== 8'h01)
            $display("FAIL abort_err_single: abort_err=%b abort_cnt=%h expected 0/01", abort_err, abort_cnt);
        else
            passed++;
`endif
        cyc(1'b1, 8'h78);
        cyc(1'b1, 8'h9A);
        cyc(1'b1, 8'hBC);
        checks++;
        if (valid_out !== 1'b1)
            $display("FAIL abort_next_word: valid_out=%b expected 1", valid_out);
        else
            passed++;
        cyc(1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_word;
        cyc(1'b1, 8'hBB);
        cyc(1'b1, 8'hCC);
        reset = 1'b1;
        cyc(1'b1, 8'h99);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid_out !== 1'b0 || data_out !== 32'h0)
            $display("FAIL midreset_state: busy=%b valid_out=%b data_out=%h expected 0/0/0",
                     busy, valid_out, data_out);
        else
            passed++;
        exp_q.push_back(32'hDDEE1122);
        cyc(1'b1, 8'hDD);
        cyc(1'b1, 8'hEE);
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        checks++;
        if (valid_out !== 1'b1)
            $display("FAIL midreset_next_word: valid_out=%b expected 1", valid_out);
        else
            passed++;
        cyc(1'b0, 8'h00);
    endtask

    task automatic test_idle_gaps;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h5A);
            checks++;
`ifdef CONV_8_32_ABORT_ERR_EN
            if (valid_out !== 1'b0 || busy !== 1'b0 || abort_err !== 1'b0)
                $display("FAIL idle_quiet: cycle %0d valid_out=%b busy=%b abort_err=%b expected 0/0/0",
                         i, valid_out, busy, abort_err);
`else
            if (valid_out !== 1'b0 || busy !== 1'b0)
                $display("FAIL idle_quiet: cycle %0d valid_out=%b busy=%b expected 0/0", i, valid_out, busy);
`endif
            else
                passed++;
        end
        checks++;
        if (data_out !== 32'hDDEE1122)
            $display("FAIL idle_hold: data_out=%h expected ddee1122", data_out);
        else
            passed++;
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        test_reset;
        test_single_word;
        test_back_to_back;
        test_gap_abort;
        test_reset_mid_word;
        test_idle_gaps;
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d words outstanding, expected 0", exp_q.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
